// File: rtl/and3_bist_checker.sv
// Built-in self-test for a 3-input AND gate: steps {w,x,y} through all 8 patterns, checks z, counts mismatches.
// Optional first-failure capture is enabled by defining AND3_BIST_FIRST_FAIL_EN.
module and3_bist_checker #(
  parameter int HOLD_CYCLES = 2,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             w,
  output logic             x,
  output logic             y,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef AND3_BIST_FIRST_FAIL_EN
  ,
  output logic [2:0]       first_fail,
  output logic             fail_seen
`endif
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  state_t           state, state_next;
  logic [2:0]       pattern, pattern_next;
  logic [7:0]       hold, hold_next;
  logic [2:0]       wxy_next;
  logic             busy_next, done_next;
  logic [ERR_W-1:0] err_next;
  logic             mismatch;
`ifdef AND3_BIST_FIRST_FAIL_EN
  logic [2:0]       first_fail_next;
  logic             fail_seen_next;
`endif

  assign mismatch = (z != (w & x & y));
  assign pass     = done && (err_count == '0);

  // NOTE: every variable gets its hold value first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_next   = state;
    pattern_next = pattern;
    hold_next    = hold;
    wxy_next     = {w, x, y};
    busy_next    = busy;
    done_next    = done;
    err_next     = err_count;
`ifdef AND3_BIST_FIRST_FAIL_EN
    first_fail_next = first_fail;
    fail_seen_next  = fail_seen;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next   = APPLY;
          pattern_next = 3'd0;
          hold_next    = 8'd0;
          wxy_next     = 3'b000;
          busy_next    = 1'b1;
          done_next    = 1'b0;
          err_next     = '0;
`ifdef AND3_BIST_FIRST_FAIL_EN
          first_fail_next = 3'b000;
          fail_seen_next  = 1'b0;
`endif
        end
      end
      APPLY: begin
        if (hold == HOLD_LAST) begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_next = err_count + 1'b1;
`ifdef AND3_BIST_FIRST_FAIL_EN
            if (!fail_seen) first_fail_next = {w, x, y};
            fail_seen_next = 1'b1;
`endif
          end
          hold_next    = 8'd0;
          pattern_next = pattern + 3'd1;
          // The 7->0 wrap only ever coincides with leaving APPLY.
          if (pattern == 3'd7) begin
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            wxy_next   = 3'b000;
          end else begin
            wxy_next = pattern + 3'd1;
          end
        end else begin
          hold_next = hold + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        wxy_next   = 3'b000;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pattern   <= 3'd0;
      hold      <= 8'd0;
      {w, x, y} <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
`ifdef AND3_BIST_FIRST_FAIL_EN
      first_fail <= 3'b000;
      fail_seen  <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      pattern   <= pattern_next;
      hold      <= hold_next;
      {w, x, y} <= wxy_next;
      busy      <= busy_next;
      done      <= done_next;
      err_count <= err_next;
`ifdef AND3_BIST_FIRST_FAIL_EN
      first_fail <= first_fail_next;
      fail_seen  <= fail_seen_next;
`endif
    end
  end

endmodule
